// File: rtl/mips_regfile_param_pkg.sv
// Shared types and default geometry for the MIPS register file, decoder and hazard unit.
package mips_regfile_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_ADDR_W   = $clog2(DEF_NUM_REGS);
  localparam int DEF_NUM_RD   = 2;

endpackage

// File: rtl/mips_regfile_clear_fsm.sv
// Sequential clear engine: walks the register array one entry per cycle.
module mips_regfile_clear_fsm
  import mips_regfile_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_idx
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  clr_state_t        state;
  logic [ADDR_W-1:0] idx;

  // State and index update; clr_req is only looked at while idle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clr_req) begin
            state <= CLEAR;
            idx   <= '0;
          end
        end
        CLEAR: begin
          if (idx == LAST_IDX) begin
            state <= IDLE;
            idx   <= '0;
          end else begin
            idx <= idx + ADDR_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

  // busy decodes a single state flop, so it is registered and glitch-free.
  assign busy    = (state == CLEAR);
  assign clr_en  = busy;
  assign clr_idx = idx;

endmodule

// File: rtl/mips_regfile_param.sv
// Parametrised MIPS register file: N read ports, optional zero register,
// optional write-to-read bypass, and a sequential clear sweep.
module mips_regfile_param
  import mips_regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           we,
  input  logic [ADDR_W-1:0]              wa,
  input  logic [DATA_W-1:0]              wd,
  input  logic [NUM_RD-1:0][ADDR_W-1:0]  ra,
  output logic [NUM_RD-1:0][DATA_W-1:0]  rd,
  input  logic                           clr_req,
  output logic                           busy
);

  localparam logic [ADDR_W:0] REG_CNT = (ADDR_W + 1)'(NUM_REGS);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              clr_en;
  logic [ADDR_W-1:0] clr_idx;
  logic              wa_in_range;
  logic              wa_is_zero_reg;
  logic              write_ok;

  mips_regfile_clear_fsm #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_clear_fsm (
    .clock   (clock),
    .reset   (reset),
    .clr_req (clr_req),
    .busy    (busy),
    .clr_en  (clr_en),
    .clr_idx (clr_idx)
  );

  // A write commits only when idle, in range and not aimed at a hardwired zero.
  always_comb begin
    wa_in_range    = ({1'b0, wa} < REG_CNT);
    wa_is_zero_reg = (ZERO_REG != 0) && (wa == '0);
    write_ok       = we && !busy && wa_in_range && !wa_is_zero_reg;
  end

  // Storage: reset clears everything, the sweep clears one entry, else user write.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (clr_en) begin
      regs[clr_idx] <= '0;
    end else if (write_ok) begin
      regs[wa] <= wd;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [DATA_W-1:0] rdata;

    // Read mux: zero register, then bypass of a committing write, then storage.
    always_comb begin
      rdata = '0;
      if ((ZERO_REG != 0) && (ra[p] == '0)) begin
        rdata = '0;
      end else if ((BYPASS != 0) && write_ok && (wa == ra[p])) begin
        rdata = wd;
      end else if ({1'b0, ra[p]} < REG_CNT) begin
        rdata = regs[ra[p]];
      end
    end

    assign rd[p] = rdata;
  end

endmodule

// File: tb/tb_mips_regfile_param.sv
// Bench for mips_regfile_param: default, no-bypass and small 3-port configurations.
module tb_mips_regfile_param;

  logic clock = 1'b0;
  logic reset = 1'b1;

  // Default and no-bypass instances share their inputs.
  logic             we = 1'b0;
  logic [4:0]       wa = '0;
  logic [31:0]      wd = '0;
  logic [1:0][4:0]  ra = '0;
  logic             clr = 1'b0;
  logic [1:0][31:0] rd_a, rd_b;
  logic             busy_a, busy_b;

  // Small instance: 16-bit, 8 regs, 3 read ports, no zero register.
  logic             we_c = 1'b0;
  logic [2:0]       wa_c = '0;
  logic [15:0]      wd_c = '0;
  logic [2:0][2:0]  ra_c = '0;
  logic             clr_c = 1'b0;
  logic [2:0][15:0] rd_c;
  logic             busy_c;

  logic [31:0] model   [32];
  logic [15:0] model_c [8];
  logic [31:0] sb_q [$];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clock = ~clock;

  mips_regfile_param #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clock(clock), .reset(reset), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd_a),
    .clr_req(clr), .busy(busy_a));

  mips_regfile_param #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(2), .ZERO_REG(1), .BYPASS(0)) dut_b (
    .clock(clock), .reset(reset), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd_b),
    .clr_req(clr), .busy(busy_b));

  mips_regfile_param #(.DATA_W(16), .NUM_REGS(8), .NUM_RD(3), .ZERO_REG(0), .BYPASS(1)) dut_c (
    .clock(clock), .reset(reset), .we(we_c), .wa(wa_c), .wd(wd_c), .ra(ra_c), .rd(rd_c),
    .clr_req(clr_c), .busy(busy_c));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input logic [31:0] e);
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input string tag, input logic [31:0] got);
    logic [31:0] e;
    e = (sb_q.size() != 0) ? sb_q.pop_front() : 32'hxxxx_xxxx;
    check(tag, got, e);
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  // One idle cycle on the 32x32 pair: drive, check reads, commit.
  task automatic cyc(input logic w, input logic [4:0] a, input logic [31:0] d,
                     input logic [4:0] r0, input logic [4:0] r1);
    we = w; wa = a; wd = d; ra[0] = r0; ra[1] = r1;
    sb_push((r0 == 0) ? 32'h0 : (w && a == r0) ? d : model[r0]);
    sb_push((r1 == 0) ? 32'h0 : (w && a == r1) ? d : model[r1]);
    sb_push((r0 == 0) ? 32'h0 : model[r0]);
    sb_push((r1 == 0) ? 32'h0 : model[r1]);
    #2;
    sb_pop("a_rd0", rd_a[0]);
    sb_pop("a_rd1", rd_a[1]);
    sb_pop("b_rd0", rd_b[0]);
    sb_pop("b_rd1", rd_b[1]);
    if (w && a != 0) model[a] = d;
    step();
    we = 1'b0;
  endtask

  task automatic cyc_c(input logic w, input logic [2:0] a, input logic [15:0] d,
                       input logic [2:0] r0, input logic [2:0] r1, input logic [2:0] r2);
    we_c = w; wa_c = a; wd_c = d; ra_c[0] = r0; ra_c[1] = r1; ra_c[2] = r2;
    sb_push({16'h0, (w && a == r0) ? d : model_c[r0]});
    sb_push({16'h0, (w && a == r1) ? d : model_c[r1]});
    sb_push({16'h0, (w && a == r2) ? d : model_c[r2]});
    #2;
    sb_pop("c_rd0", {16'h0, rd_c[0]});
    sb_pop("c_rd1", {16'h0, rd_c[1]});
    sb_pop("c_rd2", {16'h0, rd_c[2]});
    if (w) model_c[a] = d;
    step();
    we_c = 1'b0;
  endtask

  task automatic read_all();
    for (int i = 0; i < 32; i++) cyc(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned cnt;
    foreach (model[i]) model[i] = '0;
    foreach (model_c[i]) model_c[i] = '0;

    // Reset state
    step(); step();
    reset = 1'b0;
    check("busy_rst_a", {31'h0, busy_a}, 32'h0);
    check("busy_rst_c", {31'h0, busy_c}, 32'h0);
    read_all();
    for (int i = 0; i < 8; i++) cyc_c(1'b0, 3'd0, 16'h0, 3'(i), 3'(7 - i), 3'(i));

    // Basic write/read and zero register
    cyc(1'b1, 5'd5, 32'hDEADBEEF, 5'd1, 5'd2);
    cyc(1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
    cyc(1'b1, 5'd0, 32'h1, 5'd0, 5'd5);
    cyc(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

    // Same-cycle bypass (dut_b returns the old value)
    cyc(1'b1, 5'd7, 32'h12345678, 5'd7, 5'd5);
    cyc(1'b0, 5'd0, 32'h0, 5'd7, 5'd7);

    // Fill, then sweep with a simultaneous write to r9
    for (int i = 1; i < 32; i++) cyc(1'b1, 5'(i), 32'(i), 5'(i), 5'd0);
    clr = 1'b1;
    cyc(1'b1, 5'd9, 32'h99, 5'd9, 5'd3);
    clr = 1'b0;
    cnt = 0;
    for (int g = 0; g < 100 && busy_a === 1'b1; g++) begin
      cnt++;
      if (cnt == 1) begin
        we = 1'b1; wa = 5'd3; wd = 32'hFFFF; ra[0] = 5'd3; ra[1] = 5'd9;
        sb_push(32'h3);
        sb_push(32'h99);
        #2;
        sb_pop("sweep_nobypass", rd_a[0]);
        sb_pop("sweep_r9_kept", rd_a[1]);
      end else if (cnt == 20) begin
        we = 1'b1; wa = 5'd3; wd = 32'hFFFF;
      end else if (cnt == 5) begin
        clr = 1'b1;
      end
      step();
      we = 1'b0; clr = 1'b0;
    end
    check("sweep_len_a", cnt, 32'd32);
    check("busy_after_sweep", {31'h0, busy_a}, 32'h0);
    foreach (model[i]) model[i] = '0;
    read_all();
    cyc(1'b1, 5'd4, 32'h44, 5'd4, 5'd3);
    cyc(1'b0, 5'd0, 32'h0, 5'd4, 5'd3);

    // Reset in the middle of a sweep
    for (int i = 1; i < 32; i++) cyc(1'b1, 5'(i), 32'(i) + 32'h100, 5'(i), 5'd0);
    clr = 1'b1;
    step();
    clr = 1'b0;
    cnt = 0;
    for (int g = 0; g < 100 && busy_a === 1'b1 && cnt < 10; g++) begin
      cnt++;
      if (cnt < 10) step();
    end
    check("busy_before_rst", {31'h0, busy_a}, 32'h1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("busy_after_rst", {31'h0, busy_a}, 32'h0);
    foreach (model[i]) model[i] = '0;
    cyc(1'b1, 5'd12, 32'hCAFE, 5'd12, 5'd20);
    read_all();

    // Small configuration
    cyc_c(1'b1, 3'd0, 16'hABCD, 3'd0, 3'd1, 3'd2);
    cyc_c(1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 3'd0);
    for (int i = 1; i < 8; i++) cyc_c(1'b1, 3'(i), 16'h1000 + 16'(i), 3'd0, 3'(i), 3'd7);
    cyc_c(1'b0, 3'd0, 16'h0, 3'd1, 3'd4, 3'd7);
    cyc_c(1'b0, 3'd0, 16'h0, 3'd2, 3'd5, 3'd0);
    clr_c = 1'b1;
    cyc_c(1'b0, 3'd0, 16'h0, 3'd3, 3'd6, 3'd0);
    clr_c = 1'b0;
    cnt = 0;
    for (int g = 0; g < 100 && busy_c === 1'b1; g++) begin
      cnt++;
      step();
    end
    check("sweep_len_c", cnt, 32'd8);
    foreach (model_c[i]) model_c[i] = '0;
    cyc_c(1'b0, 3'd0, 16'h0, 3'd0, 3'd3, 3'd7);
    cyc_c(1'b0, 3'd0, 16'h0, 3'd1, 3'd4, 3'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mips_regfile_param.md
# mips_regfile_param

Parametrised successor to the 32x32 MIPS register file: configurable data width, register count and number of read ports, with an optional hardwired zero register and same-cycle write-to-read bypass. It also has a sequential clear engine that zeros the array one entry per cycle on request and reports `busy` while doing so. It sits in the decode stage of the MIPS datapath, fed by the instruction decoder and written back from the WB stage.

## Interface
Parameters:
- `DATA_W`, 32: register width in bits.
- `NUM_REGS`, 32: number of registers; must be ≥2.
- `ADDR_W`, `$clog2(NUM_REGS)`: address width (derived).
- `NUM_RD`, 2: number of independent read ports; must be ≥1.
- `ZERO_REG`, 1: 1 means register 0 always reads 0 and ignores writes.
- `BYPASS`, 1: 1 means a read of the register being written this cycle returns the write data.

Ports:
- `clock`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high. Clears all registers to 0. Returns the FSM to IDLE and drives `busy`=0.
- `we`  in  1: write enable.
- `wa`  in  `ADDR_W`: write address.
- `wd`  in  `DATA_W`: write data.
- `ra`  in  `NUM_RD`x`ADDR_W`: read addresses, packed array.
- `rd`  out  `NUM_RD`x`DATA_W`: read data, combinational from `ra`.
- `clr_req`  in  1: start a clear sweep. Level is sampled only in IDLE.
- `busy`  out  1: high while a clear sweep runs; 0 out of reset.

## Operation
- Write: on a rising edge with `we`=1, `reset`=0 and FSM in IDLE, `regs[wa]` ← `wd`.
  - If `ZERO_REG`=1 and `wa`=0, the write is discarded.
  - If `wa` ≥ `NUM_REGS`, the write is discarded.
- Read: each `rd[p]` is combinational.
  - If `ZERO_REG`=1 and `ra[p]`=0, `rd[p]`=0.
  - Else if `BYPASS`=1, `we`=1, FSM is IDLE, `wa`=`ra[p]`, and the write is not discarded, `rd[p]`=`wd`.
  - Else `rd[p]`=`regs[ra[p]]`.
  - An out-of-range `ra` reads 0.
- Clear FSM states are IDLE and CLEAR, with an index counter `idx` of width `ADDR_W`.
  - IDLE, `clr_req`=1: go to CLEAR with `idx`=0. `busy` goes high on the next cycle.
  - CLEAR: each cycle `regs[idx]` ← 0 and `idx` increments. When `idx`=`NUM_REGS`-1, that entry is cleared and the FSM returns to IDLE.
  - A sweep therefore takes exactly `NUM_REGS` cycles of `busy`=1.
  - In CLEAR, `we` is ignored: user writes are dropped, not queued. Reads return current storage, which may be partly cleared. Bypass is disabled.
  - `clr_req` in CLEAR is ignored; there is no restart.
- `reset` has priority over everything. When asserted mid-sweep, all registers are zeroed at that edge, the FSM goes to IDLE and `idx`=0.

## Timing
- Read latency is 0 cycles (combinational). Write-to-read without bypass is 1 cycle: the value is visible after the edge.
- `clr_req` sampled at edge N makes `busy`=1 from N+1 through N+`NUM_REGS`. The first accepted write is at edge N+`NUM_REGS`+1 or later.
- `busy` is registered and glitch-free. Reset value is 0. After reset every `rd` reads 0.
- Simultaneous `we` and `clr_req` in IDLE: the write commits and the sweep starts; that register is cleared later in the sweep.

## Structure
- Package `mips_regfile_pkg`:
  - `typedef enum logic {IDLE, CLEAR} clr_state_t`.
  - Default width and depth constants, shared with the decoder and hazard unit.
- Sub-module `mips_regfile_clear_fsm`: state, `idx` counter and `busy`. It outputs the clear enable and clear index to the array.
- The storage array and read muxing, with a generate loop over `NUM_RD`, stay in the top module.

## Test plan
- Reset, then read all addresses on both ports -> all 0, `busy`=0.
- Write `0xDEADBEEF` to r5, then read r5 on port 0 and r5 on port 1 next cycle -> both `0xDEADBEEF`. Write `0x1` to r0 -> r0 still reads 0.
- Same cycle: `we`=1, `wa`=7, `wd`=`0x12345678`, `ra[0]`=7 -> `rd[0]`=`0x12345678` combinationally (`BYPASS`=1). With `BYPASS`=0 -> old value.
- Fill r1..r31 with their index, pulse `clr_req` -> `busy` high for exactly 32 cycles. A write to r3 during the sweep is dropped. Afterwards all registers read 0.
- Start a sweep, assert `reset` at cycle 10 of the sweep -> next cycle `busy`=0, FSM IDLE, all registers 0. A write is accepted the following cycle.
- Instantiate with `DATA_W`=16, `NUM_REGS`=8, `NUM_RD`=3, `ZERO_REG`=0:
  - Write `0xABCD` to r0 -> reads `0xABCD`.
  - A sweep takes 8 cycles.
  - Three ports read distinct registers concurrently with correct values.
